// File: rtl/picomips_core_if.sv
// picomips_core_if: valid/ready input and output streams of the picoMips core.
// The core connects through the master modport; the producer/consumer side
// (board I/O or a host) connects through the slave modport.
interface picomips_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
endinterface

// File: rtl/picomips_core.sv
// picomips_core: parametrised accumulator-style CPU with a run-time loadable
// program memory, fractional multiply, branches, HALT and valid/ready I/O.
// Each instruction is fetched combinationally from mem[pc] and retires in one
// cycle unless an IN or OUT handshake stalls it.
module picomips_core #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 4,
    parameter int PC_W   = 5
) (
    input  logic                       Clock,
    input  logic                       nReset,
    input  logic                       run,
    input  logic                       prog_we,
    input  logic [PC_W-1:0]            prog_addr,
    input  logic [4+REG_AW+DATA_W-1:0] prog_data,
    picomips_core_if.master            io,
    output logic                       halted,
    output logic [PC_W-1:0]            pc
);
    localparam int IW    = 4 + REG_AW + DATA_W;
    localparam int NREG  = 1 << REG_AW;
    localparam int DEPTH = 1 << PC_W;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_MULI = 4'd4;
    localparam logic [3:0] OP_MUL  = 4'd5;
    localparam logic [3:0] OP_IN   = 4'd6;
    localparam logic [3:0] OP_OUT  = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8;
    localparam logic [3:0] OP_BZ   = 4'd9;
    localparam logic [3:0] OP_BNZ  = 4'd10;
    localparam logic [3:0] OP_HALT = 4'd11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // Q1.(DATA_W-1) multiply: full signed product, keep the bits just below
    // the redundant sign bit; overflow (-1 * -1) wraps rather than saturates.
    function automatic logic signed [DATA_W-1:0] frac_mul(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] y
    );
        logic signed [2*DATA_W-1:0] xe;
        logic signed [2*DATA_W-1:0] ye;
        logic signed [2*DATA_W-1:0] p;
        xe = {{DATA_W{x[DATA_W-1]}}, x};
        ye = {{DATA_W{y[DATA_W-1]}}, y};
        p  = xe * ye;
        return p[2*DATA_W-2:DATA_W-1];
    endfunction

    logic [IW-1:0]            mem  [DEPTH];
    logic [DATA_W-1:0]        regs [NREG];
    logic [1:0]               state;

    logic [IW-1:0]            instr;
    logic [3:0]               op;
    logic [REG_AW-1:0]        rd;
    logic [REG_AW-1:0]        rs;
    logic [DATA_W-1:0]        fld;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic [PC_W-1:0]          pc_inc;
    logic [PC_W-1:0]          tgt;

    logic                     exec;
    logic                     to_idle;
    logic                     stall;
    logic                     wr_en;
    logic [DATA_W-1:0]        wr_val;
    logic                     do_out;
    logic                     do_halt;
    logic [PC_W-1:0]          pc_nxt;

    assign instr  = mem[pc];
    assign op     = instr[IW-1 -: 4];
    assign rd     = instr[DATA_W +: REG_AW];
    assign fld    = instr[DATA_W-1:0];
    assign rs     = fld[DATA_W-1 -: REG_AW];
    // Register 0 is reset to zero and never written, so it always reads zero.
    assign a      = regs[rd];
    assign b      = regs[rs];
    assign pc_inc = pc + 1'b1;
    assign tgt    = fld[PC_W-1:0];

    // Dropping run abandons whatever is executing, including a stalled IN/OUT.
    assign exec    = (state == S_RUN) && run;
    assign to_idle = !run && (state != S_IDLE);

    assign io.in_ready = exec && (op == OP_IN);
    assign halted      = (state == S_HALT);

    // Decode/execute: result, write enable, stall and next pc of the current instruction.
    always_comb begin
        wr_en   = 1'b0;
        wr_val  = a;
        stall   = 1'b0;
        do_out  = 1'b0;
        do_halt = 1'b0;
        pc_nxt  = pc_inc;
        case (op)
            OP_ADD:  begin wr_en = 1'b1; wr_val = a + b; end
            OP_SUB:  begin wr_en = 1'b1; wr_val = a - b; end
            OP_MOV:  begin wr_en = 1'b1; wr_val = b; end
            OP_ADDI: begin wr_en = 1'b1; wr_val = a + fld; end
            OP_MULI: begin wr_en = 1'b1; wr_val = frac_mul(a, fld); end
            OP_MUL:  begin wr_en = 1'b1; wr_val = frac_mul(a, b); end
            OP_IN: begin
                if (io.in_valid) begin
                    wr_en  = 1'b1;
                    wr_val = io.in_data;
                end else begin
                    stall = 1'b1;
                end
            end
            OP_OUT: begin
                if (io.out_valid && !io.out_ready) stall = 1'b1;
                else                               do_out = 1'b1;
            end
            OP_JMP:  pc_nxt = tgt;
            OP_BZ:   if (a == '0) pc_nxt = tgt;
            OP_BNZ:  if (a != '0) pc_nxt = tgt;
            OP_HALT: begin do_halt = 1'b1; pc_nxt = pc; end
            default: ;
        endcase
    end

    // Program memory: written only in idle/load mode, never reset.
    always_ff @(posedge Clock) begin
        if (!run && prog_we) mem[prog_addr] <= prog_data;
    end

    // Control FSM and program counter.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_RUN;
                    pc <= '0;
                end
                S_RUN: begin
                    if (!run) begin
                        state <= S_IDLE;
                        pc    <= '0;
                    end else if (!stall) begin
                        pc <= pc_nxt;
                        if (do_halt) state <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        state <= S_IDLE;
                        pc    <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    pc    <= '0;
                end
            endcase
        end
    end

    // Register file write-back; register 0 discards writes.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (exec && wr_en && (rd != '0)) begin
            regs[rd] <= wr_val;
        end
    end

    // Output register: a new OUT word wins over acceptance of the previous one.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            io.out_data  <= '0;
            io.out_valid <= 1'b0;
        end else if (exec && do_out) begin
            io.out_data  <= a;
            io.out_valid <= 1'b1;
        end else if (to_idle || io.out_ready) begin
            io.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_picomips_core.sv
// tb_picomips_core: table-driven, hand-sequenced and randomized checks of
// picomips_core against an instruction-level model of the ISA.
`timescale 1ns/1ps
module tb_picomips_core;
    localparam int DW    = 8;
    localparam int RA    = 4;
    localparam int PW    = 5;
    localparam int IW    = 16;
    localparam int DEPTH = 32;

    logic          Clock = 1'b0;
    logic          nReset = 1'b0;
    logic          run = 1'b0;
    logic          prog_we = 1'b0;
    logic [PW-1:0] prog_addr = '0;
    logic [IW-1:0] prog_data = '0;
    logic          halted;
    logic [PW-1:0] pc;

    logic          run16 = 1'b0;
    logic          prog_we16 = 1'b0;
    logic [5:0]    prog_addr16 = '0;
    logic [22:0]   prog_data16 = '0;
    logic          halted16;
    logic [5:0]    pc16;

    picomips_core_if #(.DATA_W(DW)) io();
    picomips_core_if #(.DATA_W(16)) io16();

    picomips_core #(.DATA_W(DW), .REG_AW(RA), .PC_W(PW)) dut (
        .Clock(Clock), .nReset(nReset), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .io(io),
        .halted(halted), .pc(pc)
    );

    picomips_core #(.DATA_W(16), .REG_AW(3), .PC_W(6)) dut16 (
        .Clock(Clock), .nReset(nReset), .run(run16), .prog_we(prog_we16),
        .prog_addr(prog_addr16), .prog_data(prog_data16), .io(io16),
        .halted(halted16), .pc(pc16)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;

    logic [IW-1:0] prog_img [DEPTH];
    int            in_q[$];
    logic [7:0]    got_q[$];

    typedef struct {
        int op;
        int a;
        int b;
        int exp;
    } vec_t;
    vec_t vt[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int fld);
        logic [3:0] o;
        logic [3:0] r;
        logic [7:0] f;
        o = op[3:0];
        r = rd[3:0];
        f = fld[7:0];
        return {o, r, f};
    endfunction

    function automatic logic [22:0] enc16(input int op, input int rd, input int fld);
        logic [3:0]  o;
        logic [2:0]  r;
        logic [15:0] f;
        o = op[3:0];
        r = rd[2:0];
        f = fld[15:0];
        return {o, r, f};
    endfunction

    function automatic int sx8(input int x);
        int v;
        v = x & 255;
        if (v >= 128) v -= 256;
        return v;
    endfunction

    // Instruction-level model: runs the program image to HALT, producing the
    // ordered list of words the program sends out.
    task automatic model_run(input int ins[$], output int outs[$], output bit ok);
        int r[16];
        int p, op, rd, rs, f, a, b, wv, nx;
        bit wr;
        logic [IW-1:0] w;
        for (int i = 0; i < 16; i++) r[i] = 0;
        p = 0;
        ok = 0;
        outs = {};
        repeat (2000) begin
            w  = prog_img[p];
            op = int'(w[15:12]);
            rd = int'(w[11:8]);
            f  = int'(w[7:0]);
            rs = int'(w[7:4]);
            a  = r[rd];
            b  = r[rs];
            nx = (p + 1) % DEPTH;
            wr = 0;
            wv = 0;
            case (op)
                0: begin wr = 1; wv = a + b; end
                1: begin wr = 1; wv = a - b; end
                2: begin wr = 1; wv = b; end
                3: begin wr = 1; wv = a + sx8(f); end
                4: begin wr = 1; wv = (a * sx8(f)) >>> 7; end
                5: begin wr = 1; wv = (a * b) >>> 7; end
                6: begin
                    if (ins.size() == 0) return;
                    wr = 1;
                    wv = ins.pop_front();
                end
                7: outs.push_back(a & 255);
                8: nx = f % DEPTH;
                9: if (a == 0) nx = f % DEPTH;
                10: if (a != 0) nx = f % DEPTH;
                11: begin ok = 1; return; end
                default: ;
            endcase
            if (wr && rd != 0) r[rd] = sx8(wv);
            p = nx;
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < DEPTH; i++) prog_img[i] = enc(11, 0, 0);
    endtask

    task automatic hard_reset();
        @(negedge Clock);
        run = 1'b0;
        nReset = 1'b0;
        #2;
        nReset = 1'b1;
    endtask

    task automatic go_idle();
        @(negedge Clock);
        run = 1'b0;
        io.in_valid = 1'b0;
        repeat (2) @(negedge Clock);
    endtask

    task automatic load_img();
        go_idle();
        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = i[PW-1:0];
            prog_data = prog_img[i];
            @(negedge Clock);
        end
        prog_we = 1'b0;
    endtask

    task automatic start();
        load_img();
        run = 1'b1;
    endtask

    // Drives the streams with the given valid/ready percentages until the
    // core halts with nothing left to deliver, or the budget runs out.
    task automatic execute(input int budget, input int vpct, input int rpct, output bit ok);
        int t;
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            if (in_q.size() > 0 && $urandom_range(99) < vpct) begin
                t = in_q[0];
                io.in_valid = 1'b1;
                io.in_data  = t[7:0];
            end else begin
                io.in_valid = 1'b0;
                io.in_data  = 8'($urandom);
            end
            io.out_ready = ($urandom_range(99) < rpct);
            #1;
            if (halted && !io.out_valid) begin
                ok = 1;
                break;
            end
            if (io.out_valid && io.out_ready) got_q.push_back(io.out_data);
            if (io.in_valid && io.in_ready) void'(in_q.pop_front());
            @(negedge Clock);
        end
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok, mok;
        int outs[$];
        int ins[$];
        int ops[12];
        int len, sel, op, rd, rs;
        logic [22:0] img16 [7];
        logic [15:0] got16[$];

        io.in_valid = 1'b0;
        io.in_data = '0;
        io.out_ready = 1'b0;
        io16.in_valid = 1'b0;
        io16.in_data = '0;
        io16.out_ready = 1'b0;

        vt[0] = '{0, 5, 3, 8};
        vt[1] = '{0, 127, 1, 128};
        vt[2] = '{1, 3, 5, 254};
        vt[3] = '{1, 128, 1, 127};
        vt[4] = '{2, 17, 34, 34};
        vt[5] = '{3, 5, 249, 254};
        vt[6] = '{4, 40, 96, 30};
        vt[7] = '{4, 40, 192, 236};
        vt[8] = '{5, 128, 128, 128};
        vt[9] = '{5, 64, 64, 32};

        // Reset state
        #1;
        check("rst_out_data", io.out_data, 0);
        check("rst_out_valid", io.out_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_in_ready", io.in_ready, 0);
        #20;
        nReset = 1'b1;

        // Table: IN r1; IN r2; <op> r1; OUT r1; HALT
        for (int v = 0; v < 10; v++) begin
            clear_img();
            prog_img[0] = enc(6, 1, 0);
            prog_img[1] = enc(6, 2, 0);
            if (vt[v].op == 3 || vt[v].op == 4) prog_img[2] = enc(vt[v].op, 1, vt[v].b);
            else                                prog_img[2] = enc(vt[v].op, 1, 2 * 16);
            prog_img[3] = enc(7, 1, 0);
            hard_reset();
            start();
            in_q = {vt[v].a, vt[v].b};
            got_q = {};
            execute(200, 60, 60, ok);
            check($sformatf("vec%0d_halt", v), {31'd0, ok}, 1);
            check($sformatf("vec%0d_count", v), got_q.size(), 1);
            if (got_q.size() > 0) check($sformatf("vec%0d_op%0d", v, vt[v].op), got_q[0], vt[v].exp);
        end

        // ADDI r1,5; ADDI r1,-7; OUT r1; HALT
        clear_img();
        prog_img[0] = enc(3, 1, 5);
        prog_img[1] = enc(3, 1, 249);
        prog_img[2] = enc(7, 1, 0);
        hard_reset();
        start();
        in_q = {};
        got_q = {};
        execute(50, 0, 100, ok);
        check("basic_halted", halted, 1);
        check("basic_pc", pc, 3);
        check("basic_count", got_q.size(), 1);
        if (got_q.size() > 0) check("basic_out", got_q[0], 8'hFE);

        // IN stall, then a prog_we during run that must be ignored
        clear_img();
        prog_img[0] = enc(6, 1, 0);
        prog_img[1] = enc(7, 1, 0);
        hard_reset();
        start();
        @(negedge Clock);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("install_pc", pc, 0);
            check("install_ready", io.in_ready, 1);
            if (c == 2) begin
                prog_we = 1'b1;
                prog_addr = 5'd1;
                prog_data = enc(11, 0, 0);
            end else begin
                prog_we = 1'b0;
            end
            @(negedge Clock);
        end
        prog_we = 1'b0;
        io.in_valid = 1'b1;
        io.in_data = 8'h5A;
        @(negedge Clock);
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        #1;
        check("in_xfer_pc", pc, 1);
        @(negedge Clock);
        #1;
        check("prog_we_ignored_valid", io.out_valid, 1);
        check("prog_we_ignored_data", io.out_data, 8'h5A);
        io.out_ready = 1'b0;

        // Two OUTs with out_ready low: the second stalls until out_ready pulses
        clear_img();
        prog_img[0] = enc(3, 1, 1);
        prog_img[1] = enc(7, 1, 0);
        prog_img[2] = enc(3, 1, 1);
        prog_img[3] = enc(7, 1, 0);
        hard_reset();
        io.out_ready = 1'b0;
        start();
        repeat (10) @(negedge Clock);
        #1;
        check("outstall_pc", pc, 3);
        check("outstall_data", io.out_data, 1);
        check("outstall_valid", io.out_valid, 1);
        io.out_ready = 1'b1;
        @(negedge Clock);
        io.out_ready = 1'b0;
        #1;
        check("outpulse_pc", pc, 4);
        check("outpulse_data", io.out_data, 2);
        check("outpulse_valid", io.out_valid, 1);
        @(negedge Clock);
        #1;
        check("outpulse_halted", halted, 1);
        // Asynchronous reset mid-cycle
        #2;
        nReset = 1'b0;
        #1;
        check("async_rst_data", io.out_data, 0);
        check("async_rst_valid", io.out_valid, 0);
        check("async_rst_halted", halted, 0);
        check("async_rst_pc", pc, 0);
        #3;
        nReset = 1'b1;

        // Loop: r1=3; ADDI r1,-1; BNZ r1,1; OUT r1; HALT
        clear_img();
        prog_img[0] = enc(3, 1, 3);
        prog_img[1] = enc(3, 1, 255);
        prog_img[2] = enc(10, 1, 1);
        prog_img[3] = enc(7, 1, 0);
        hard_reset();
        start();
        in_q = {};
        got_q = {};
        execute(100, 0, 100, ok);
        check("loop_halt", {31'd0, ok}, 1);
        check("loop_count", got_q.size(), 1);
        if (got_q.size() > 0) check("loop_r1", got_q[0], 0);

        // JMP 31 then NOP at 31: pc wraps to 0
        clear_img();
        prog_img[0] = enc(8, 0, 31);
        prog_img[31] = enc(12, 0, 0);
        hard_reset();
        start();
        @(negedge Clock);
        @(negedge Clock);
        #1;
        check("jmp_pc31", pc, 31);
        @(negedge Clock);
        #1;
        check("wrap_pc0", pc, 0);

        // Writes to r0 are discarded
        clear_img();
        prog_img[0] = enc(3, 0, 9);
        prog_img[1] = enc(7, 0, 0);
        hard_reset();
        start();
        in_q = {};
        got_q = {};
        execute(50, 0, 100, ok);
        check("r0_count", got_q.size(), 1);
        if (got_q.size() > 0) check("r0_zero", got_q[0], 0);

        // run=0 during an IN stall, then rerun with registers retained
        clear_img();
        prog_img[0] = enc(3, 1, 4);
        prog_img[1] = enc(7, 1, 0);
        prog_img[2] = enc(6, 2, 0);
        prog_img[3] = enc(7, 2, 0);
        hard_reset();
        io.out_ready = 1'b0;
        start();
        repeat (6) @(negedge Clock);
        #1;
        check("abort_pc_before", pc, 2);
        check("abort_valid_before", io.out_valid, 1);
        run = 1'b0;
        @(negedge Clock);
        #1;
        check("abort_pc", pc, 0);
        check("abort_valid", io.out_valid, 0);
        check("abort_in_ready", io.in_ready, 0);
        run = 1'b1;
        in_q = {7};
        got_q = {};
        execute(100, 100, 100, ok);
        check("rerun_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("rerun_out0", got_q[0], 8);
            check("rerun_out1", got_q[1], 7);
        end

        // Randomized straight-line programs with forward branches vs the model
        ops = '{0, 1, 2, 3, 4, 5, 6, 7, 7, 9, 10, 8};
        for (int t = 0; t < 25; t++) begin
            clear_img();
            len = $urandom_range(3, 14);
            for (int i = 0; i < len; i++) begin
                sel = $urandom_range(0, 11);
                op  = ops[sel];
                rd  = $urandom_range(0, 3);
                rs  = $urandom_range(0, 3);
                if (op == 0 || op == 1 || op == 2 || op == 5)
                    prog_img[i] = enc(op, rd, rs * 16);
                else if (op >= 8)
                    prog_img[i] = enc(op, rd, $urandom_range(i + 1, len));
                else
                    prog_img[i] = enc(op, rd, $urandom_range(0, 255));
            end
            ins = {};
            for (int i = 0; i < 16; i++) ins.push_back($urandom_range(0, 255));
            hard_reset();
            start();
            in_q = ins;
            got_q = {};
            execute(600, 70, 70, ok);
            model_run(ins, outs, mok);
            check($sformatf("rand%0d_halt", t), {31'd0, ok}, {31'd0, mok});
            check($sformatf("rand%0d_count", t), got_q.size(), outs.size());
            for (int i = 0; i < got_q.size() && i < outs.size(); i++)
                check($sformatf("rand%0d_out%0d", t, i), got_q[i], outs[i]);
        end

        // Wide configuration: DATA_W=16, REG_AW=3, PC_W=6
        hard_reset();
        img16[0] = enc16(3, 1, 16'h7FFF);
        img16[1] = enc16(3, 1, 1);
        img16[2] = enc16(7, 1, 0);
        img16[3] = enc16(3, 2, 16'h4000);
        img16[4] = enc16(4, 2, 16'h4000);
        img16[5] = enc16(7, 2, 0);
        img16[6] = enc16(11, 0, 0);
        @(negedge Clock);
        for (int i = 0; i < 7; i++) begin
            prog_we16 = 1'b1;
            prog_addr16 = i[5:0];
            prog_data16 = img16[i];
            @(negedge Clock);
        end
        prog_we16 = 1'b0;
        run16 = 1'b1;
        io16.out_ready = 1'b1;
        got16 = {};
        ok = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (halted16 && !io16.out_valid) begin
                ok = 1;
                break;
            end
            if (io16.out_valid && io16.out_ready) got16.push_back(io16.out_data);
            @(negedge Clock);
        end
        check("w16_halt", {31'd0, ok}, 1);
        check("w16_pc", pc16, 6);
        check("w16_count", got16.size(), 2);
        if (got16.size() == 2) begin
            check("w16_add_wrap", got16[0], 16'h8000);
            check("w16_frac_mul", got16[1], 16'h2000);
        end
        run16 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/picomips_core.md
Name: picomips_core

Overview:
- Parametrised successor of the 8-bit picoMips processor: a single-issue, mostly single-cycle accumulator-style CPU.
- Configurable data width, register count and program depth.
- Program memory is writable at run time through a load port, so it is no longer a constant.
- Adds SUB, register-register fractional MUL, conditional/unconditional branches and HALT.
- Replaces switch-polling with valid/ready input and output handshakes.
- Sits between board I/O (switches/LEDs, or a host) and the rest of the design.

Parameters:
- DATA_W, 8: datapath and register width; also immediate width. Must be at least REG_AW.
- REG_AW, 4: register address width; 2**REG_AW registers; register 0 always reads zero.
- PC_W, 5: program counter width; program memory depth is 2**PC_W words.
- Derived (not a parameter): IW = 4+REG_AW+DATA_W.
  - Instruction layout: {op[3:0], rd[REG_AW-1:0], fld[DATA_W-1:0]}.
  - imm = fld.
  - rs = fld[DATA_W-1 -: REG_AW].

Ports:
- Clock  in  1  system clock
- nReset  in  1  asynchronous, active-low reset
- run  in  1  1 = execute; 0 = idle/load mode
- prog_we  in  1  program write strobe; honoured only while run=0
- prog_addr  in  PC_W  program write address
- prog_data  in  IW  program write word
- in_data  in  DATA_W  input operand
- in_valid  in  1  input word available
- in_ready  out  1  core consuming in_data this cycle
- out_data  out  DATA_W  registered output (LED equivalent)
- out_valid  out  1  out_data holds an unaccepted word
- out_ready  in  1  consumer accepts out_data
- halted  out  1  core in HALT state
- pc  out  PC_W  current program counter

Behaviour:
- Reset (async):
  - pc=0, state=IDLE.
  - All registers 0, out_data=0, out_valid=0, halted=0.
  - Program memory is not reset.
- Load: while run=0, prog_we=1 writes prog_data to mem[prog_addr] at the clock edge. prog_we while run=1 is ignored.
- States: IDLE, RUN, HALT.
  - IDLE→RUN on run=1, starting at pc=0.
  - RUN→HALT on executing HALT.
  - RUN or HALT→IDLE on the clock edge after run=0. This sets pc=0 and out_valid=0; registers are retained.
- Instruction fetch is asynchronous from mem[pc]. Each instruction completes in one cycle unless it is stalled.
- Opcodes (A=reg[rd], B=reg[rs], all signed, results truncated to DATA_W with wrap and no saturation):
  - 0 ADD: rd=A+B
  - 1 SUB: rd=A-B
  - 2 MOV: rd=B
  - 3 ADDI: rd=A+imm
  - 4 MULI: P=A*imm (2*DATA_W bits signed); rd=P[2*DATA_W-2:DATA_W-1], i.e. Q1.(DATA_W-1) fractional multiply.
  - 5 MUL: same as MULI with B in place of imm.
  - 6 IN: in_ready=1 (combinational) while executing in RUN.
    - If in_valid=1: rd=in_data and pc advances.
    - Otherwise stall (pc held, no write).
  - 7 OUT: if out_valid=1 and out_ready=0, stall. Otherwise out_data<=A, out_valid<=1, pc advances.
  - 8 JMP: pc=imm[PC_W-1:0]
  - 9 BZ: if A==0 then pc=imm[PC_W-1:0], else pc+1
  - 10 BNZ: if A!=0 then pc=imm[PC_W-1:0], else pc+1
  - 11 HALT: enter HALT; pc holds.
  - 12–15: NOP.
- Writes to register 0 are discarded.
- pc+1 wraps modulo 2**PC_W.
- out_valid clears at an edge with out_ready=1 unless an OUT loads a new word in that same edge, in which case it stays 1.
- in_ready is 0 outside RUN and when the current instruction is not IN.
- An input transfer requires in_valid&in_ready at the edge.
- If run is deasserted during an IN/OUT stall, the instruction is abandoned and no register write occurs.
- halted=1 only in HALT.
- Outputs out_data, out_valid and halted are registered. pc is the register value.

Test Plan:
- Load {ADDI r1,5; ADDI r1,-7; OUT r1; HALT}, run=1, out_ready=1 → out_data=0xFE, out_valid for 1 cycle, halted=1 by cycle 4, pc=3.
- Fractional multiply, DATA_W=8: IN r3 (in_data=40), MULI r3,96; OUT r3 → 30. Same flow with MULI -64 → 0xEC (-20).
- Handshake stall: IN with in_valid=0 for 5 cycles → pc constant, in_ready=1. in_valid=1 → transfer in 1 cycle, pc+1. OUT twice with out_ready=0 → second OUT stalls until out_ready pulses.
- Loop: r1=3; loop: ADDI r1,-1; BNZ r1,loop; HALT → three loop iterations, halts with r1=0. Separately, JMP to 31 followed by a NOP at 31 → pc wraps to 0.
- Writes: prog_we while run=1 leaves memory unchanged; ADDI r0,9 then OUT r0 → 0.
- Reset/abort:
  - nReset low mid-program → all outputs 0 immediately.
  - run=0 during an IN stall → IDLE next edge, pc=0, out_valid=0; rerun executes from 0.
- Parameter sweep: DATA_W=16, REG_AW=3, PC_W=6. 0x7FFF+1 wraps to 0x8000, and MULI 0x4000 by 0x4000 gives 0x2000.
